// File: rtl/ff_bank_pkg.sv
// Shared types and the per-bit next-state function for the ff_bank storage bank.
package ff_bank_pkg;

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_SR = 2'b10,
      MODE_JK = 2'b11
   } mode_t;

   // SR illegal (S=R=1) holds; JK turns that same combination into a toggle.
   function automatic logic next_q(input mode_t mode, input logic q,
                                   input logic a, input logic b);
      logic nq;
      nq = q;
      case (mode)
         MODE_D:  nq = a;
         MODE_T:  nq = q ^ a;
         MODE_SR: begin
            case ({a, b})
               2'b10:   nq = 1'b1;
               2'b01:   nq = 1'b0;
               default: nq = q;
            endcase
         end
         MODE_JK: begin
            case ({a, b})
               2'b11:   nq = ~q;
               2'b10:   nq = 1'b1;
               2'b01:   nq = 1'b0;
               default: nq = q;
            endcase
         end
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/ff_cell.sv
// One storage bit with selectable D/T/SR/JK behaviour, clock enable and sync clear.
module ff_cell
   import ff_bank_pkg::*;
#(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic  clk,
   input  logic  rst,
   input  mode_t mode,
   input  logic  a,
   input  logic  b,
   input  logic  en,
   input  logic  clr,
   output logic  q,
   output logic  illegal
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = RESET_BIT;
      end else if (en) begin
         q_d = next_q(mode, q_q, a, b);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RESET_BIT;
      end else begin
         q_q <= q_d;
      end
   end

   // Only an update that would actually apply SR semantics can be illegal.
   assign illegal = en & ~clr & (mode == MODE_SR) & a & b;
   assign q       = q_q;

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flops sharing a registered mode, plus sticky SR-illegal flags and count.
module ff_bank
   import ff_bank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               ERR_CW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode_ld,
   input  logic [1:0]        mode_in,
   input  logic              en,
   input  logic              clr,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              err_clr,
   output logic [1:0]        mode,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qn,
   output logic [WIDTH-1:0]  err_flag,
   output logic [ERR_CW-1:0] err_cnt
);

   mode_t             mode_q;
   mode_t             mode_d;
   logic [WIDTH-1:0]  err_flag_q;
   logic [WIDTH-1:0]  err_flag_d;
   logic [ERR_CW-1:0] err_cnt_q;
   logic [ERR_CW-1:0] err_cnt_d;
   logic [WIDTH-1:0]  ill_vec;

   // Cells see mode_q, so a mode load takes effect one edge later.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell #(
         .RESET_BIT (RESET_VAL[i])
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .mode    (mode_q),
         .a       (a[i]),
         .b       (b[i]),
         .en      (en),
         .clr     (clr),
         .q       (q[i]),
         .illegal (ill_vec[i])
      );
   end

   always_comb begin
      mode_d     = mode_q;
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      if (mode_ld) begin
         mode_d = mode_t'(mode_in);
      end
      // Clearing wins over a coincident illegal event.
      if (err_clr) begin
         err_flag_d = '0;
         err_cnt_d  = '0;
      end else begin
         err_flag_d = err_flag_q | ill_vec;
         if ((|ill_vec) && (err_cnt_q != {ERR_CW{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q     <= MODE_D;
         err_flag_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         mode_q     <= mode_d;
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign mode     = mode_q;
   assign qn       = ~q;
   assign err_flag = err_flag_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: default instance plus one with RESET_VAL=0x5A and ERR_CW=2.
module tb_ff_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_ld;
   logic [1:0] mode_in;
   logic       en;
   logic       clr;
   logic [7:0] a;
   logic [7:0] b;
   logic       err_clr;

   logic [1:0] mode0, mode1;
   logic [7:0] q0, qn0, ef0, ec0;
   logic [7:0] q1, qn1, ef1;
   logic [1:0] ec1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .ERR_CW(8)) u0 (
      .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en),
      .clr(clr), .a(a), .b(b), .err_clr(err_clr), .mode(mode0), .q(q0),
      .qn(qn0), .err_flag(ef0), .err_cnt(ec0));

   ff_bank #(.WIDTH(8), .RESET_VAL(8'h5A), .ERR_CW(2)) u1 (
      .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en),
      .clr(clr), .a(a), .b(b), .err_clr(err_clr), .mode(mode1), .q(q1),
      .qn(qn1), .err_flag(ef1), .err_cnt(ec1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      en = 1'b0; mode_ld = 1'b1; mode_in = m;
      tick();
      mode_ld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; mode_ld = 1'b0; mode_in = 2'b00; en = 1'b0; clr = 1'b0;
      a = 8'h00; b = 8'h00; err_clr = 1'b0;
      #12;
      checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL reset_q0 got=%h exp=%h", q0, 8'h00); end
      checks++; if (qn0 !== 8'hFF) begin errors++; $display("FAIL reset_qn0 got=%h exp=%h", qn0, 8'hFF); end
      checks++; if (mode0 !== 2'b00) begin errors++; $display("FAIL reset_mode0 got=%h exp=%h", mode0, 2'b00); end
      checks++; if (ef0 !== 8'h00 || ec0 !== 8'h00) begin errors++; $display("FAIL reset_err0 got=%h/%h exp=00/00", ef0, ec0); end
      checks++; if (q1 !== 8'h5A || qn1 !== 8'hA5) begin errors++; $display("FAIL reset_q1 got=%h/%h exp=5a/a5", q1, qn1); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_d_mode();
      en = 1'b1; a = 8'hA5;
      tick();
      checks++; if (q0 !== 8'hA5 || qn0 !== 8'h5A) begin errors++; $display("FAIL d_load got=%h/%h exp=a5/5a", q0, qn0); end
      en = 1'b0; a = 8'h3C;
      tick();
      checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL d_hold got=%h exp=%h", q0, 8'hA5); end
   endtask

   task automatic test_mode_same_edge();
      en = 1'b1; mode_ld = 1'b1; mode_in = 2'b01; a = 8'hFF;
      tick();
      checks++; if (q0 !== 8'hFF) begin errors++; $display("FAIL modeld_old_mode got=%h exp=%h", q0, 8'hFF); end
      checks++; if (mode0 !== 2'b01) begin errors++; $display("FAIL modeld_mode got=%h exp=%h", mode0, 2'b01); end
      mode_ld = 1'b0; a = 8'h0F;
      tick();
      checks++; if (q0 !== 8'hF0) begin errors++; $display("FAIL t_toggle1 got=%h exp=%h", q0, 8'hF0); end
      tick();
      checks++; if (q0 !== 8'hFF) begin errors++; $display("FAIL t_toggle2 got=%h exp=%h", q0, 8'hFF); end
   endtask

   task automatic test_sr();
      set_mode(2'b00);
      en = 1'b1; a = 8'h00;
      tick();
      set_mode(2'b10);
      checks++; if (mode0 !== 2'b10 || q0 !== 8'h00) begin errors++; $display("FAIL sr_setup got=%h/%h exp=2/00", mode0, q0); end
      en = 1'b1; a = 8'h81; b = 8'h00;
      tick();
      checks++; if (q0 !== 8'h81) begin errors++; $display("FAIL sr_set got=%h exp=%h", q0, 8'h81); end
      a = 8'h00; b = 8'h01;
      tick();
      checks++; if (q0 !== 8'h80) begin errors++; $display("FAIL sr_reset got=%h exp=%h", q0, 8'h80); end
      a = 8'h03; b = 8'h03;
      tick();
      checks++; if (q0 !== 8'h80) begin errors++; $display("FAIL sr_illegal_hold got=%h exp=%h", q0, 8'h80); end
      checks++; if (ef0 !== 8'h03) begin errors++; $display("FAIL sr_err_flag got=%h exp=%h", ef0, 8'h03); end
      checks++; if (ec0 !== 8'h01) begin errors++; $display("FAIL sr_err_cnt got=%h exp=%h", ec0, 8'h01); end
      a = 8'h00; b = 8'h00;
      tick();
      checks++; if (ef0 !== 8'h03 || ec0 !== 8'h01) begin errors++; $display("FAIL sr_sticky got=%h/%h exp=03/01", ef0, ec0); end
   endtask

   task automatic test_jk();
      set_mode(2'b00);
      en = 1'b1; a = 8'h0F;
      tick();
      set_mode(2'b11);
      en = 1'b1; a = 8'hFF; b = 8'hFF;
      tick();
      checks++; if (q0 !== 8'hF0) begin errors++; $display("FAIL jk_toggle got=%h exp=%h", q0, 8'hF0); end
      checks++; if (ec0 !== 8'h01) begin errors++; $display("FAIL jk_no_err got=%h exp=%h", ec0, 8'h01); end
      a = 8'h00; b = 8'hF0;
      tick();
      checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL jk_reset got=%h exp=%h", q0, 8'h00); end
   endtask

   task automatic test_err_saturate();
      logic [1:0] exp1 [5];
      exp1[0] = 2'd1; exp1[1] = 2'd2; exp1[2] = 2'd3; exp1[3] = 2'd3; exp1[4] = 2'd3;
      en = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (ec0 !== 8'h00 || ef0 !== 8'h00) begin errors++; $display("FAIL errclr got=%h/%h exp=00/00", ec0, ef0); end
      set_mode(2'b10);
      en = 1'b1; a = 8'h01; b = 8'h01;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (ec1 !== exp1[i]) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, ec1, exp1[i]); end
      end
      checks++; if (ec0 !== 8'h05) begin errors++; $display("FAIL cnt_wide got=%h exp=%h", ec0, 8'h05); end
      err_clr = 1'b1; a = 8'h10; b = 8'h10;
      tick();
      err_clr = 1'b0;
      checks++; if (ec1 !== 2'd0 || ef1 !== 8'h00) begin errors++; $display("FAIL errclr_wins got=%h/%h exp=0/00", ec1, ef1); end
      checks++; if (ec0 !== 8'h00 || ef0 !== 8'h00) begin errors++; $display("FAIL errclr_wins0 got=%h/%h exp=00/00", ec0, ef0); end
   endtask

   task automatic test_clr_and_async_reset();
      clr = 1'b1; en = 1'b1; a = 8'hFF; b = 8'hFF;
      tick();
      clr = 1'b0;
      checks++; if (q1 !== 8'h5A || q0 !== 8'h00) begin errors++; $display("FAIL clr_q got=%h/%h exp=5a/00", q1, q0); end
      checks++; if (ec1 !== 2'd0) begin errors++; $display("FAIL clr_no_err got=%0d exp=0", ec1); end
      en = 1'b0; a = 8'h00; b = 8'h00; clr = 1'b1;
      tick();
      checks++; if (q1 !== 8'h5A) begin errors++; $display("FAIL clr_en0 got=%h exp=%h", q1, 8'h5A); end
      clr = 1'b0; en = 1'b1; a = 8'hFF; b = 8'h00;
      tick();
      a = 8'h03; b = 8'h03;
      tick();
      checks++; if (q1 !== 8'hFF || ec1 !== 2'd1) begin errors++; $display("FAIL pre_rst got=%h/%0d exp=ff/1", q1, ec1); end
      #2 rst = 1'b0;
      #1;
      checks++; if (q1 !== 8'h5A || qn1 !== 8'hA5) begin errors++; $display("FAIL async_rst_q got=%h/%h exp=5a/a5", q1, qn1); end
      checks++; if (mode1 !== 2'b00 || ec1 !== 2'd0 || ef1 !== 8'h00) begin errors++; $display("FAIL async_rst_ctl got=%h/%0d/%h exp=0/0/00", mode1, ec1, ef1); end
      rst = 1'b1;
      en = 1'b1; a = 8'h3C; b = 8'h00;
      tick();
      checks++; if (q1 !== 8'h3C || q0 !== 8'h3C) begin errors++; $display("FAIL rst_release got=%h/%h exp=3c/3c", q1, q0); end
   endtask

   initial begin
      test_reset();
      test_d_mode();
      test_mode_same_edge();
      test_sr();
      test_jk();
      test_err_saturate();
      test_clr_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
